// File: rtl/slave_spi.sv
// Receive end of an inter-node instruction link: deserializes one MSB-first
// frame per chip-select window and hands the word off with valid/ready.
module slave_spi #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk_in,
    input  logic             cs_n_in,
    input  logic             sdata_in,
    output logic [WIDTH-1:0] out_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W   = $clog2(WIDTH);
    localparam int SHIFT_W = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    // Bit order is {sdata, cs_n, sclk}; idle levels are data 0, cs_n 1, sclk 0.
    localparam logic [2:0] SYNC_IDLE = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    logic [2:0]         pin_bus;
    logic [2:0]         meta_reg;
    logic [2:0]         sync_reg;
    logic               sclk_prev_reg;
    logic               cs_prev_reg;
    logic [1:0]         flush_reg;
    logic               armed_reg;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SHIFT_W-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0]   instr_reg, instr_next;
    logic               valid_reg, valid_next;
    logic               frame_err_reg, frame_err_next;
    logic               overrun_reg, overrun_next;
    logic               word_done;

    logic sclk_sync, cs_n_sync, sdata_sync;
    logic sclk_rise, cs_fall, cs_rise;

    assign pin_bus    = {sdata_in, cs_n_in, sclk_in};
    assign sclk_sync  = sync_reg[0];
    assign cs_n_sync  = sync_reg[1];
    assign sdata_sync = sync_reg[2];

    assign sclk_rise = sclk_sync & ~sclk_prev_reg;
    assign cs_fall   = cs_prev_reg & ~cs_n_sync;
    assign cs_rise   = ~cs_prev_reg & cs_n_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg      <= SYNC_IDLE;
            sync_reg      <= SYNC_IDLE;
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b1;
        end else begin
            meta_reg      <= pin_bus;
            sync_reg      <= meta_reg;
            sclk_prev_reg <= sclk_sync;
            cs_prev_reg   <= cs_n_sync;
        end
    end

    // A frame already under way at reset release must not be picked up: the
    // receiver only arms once the flushed synchronizer shows cs_n high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_reg <= 2'd0;
            armed_reg <= 1'b0;
        end else begin
            if (flush_reg != 2'd2) begin
                flush_reg <= flush_reg + 2'd1;
            end
            if (flush_reg == 2'd2 && cs_n_sync) begin
                armed_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            instr_reg     <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            instr_reg     <= instr_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        instr_next     = instr_reg;
        valid_next     = valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        word_done      = 1'b0;

        // Chip-select edges are tested before sclk_rise so they take priority.
        case (state_reg)
            IDLE: begin
                if (cs_fall && armed_reg) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    shift_next = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next     = IDLE;
                    cnt_next       = '0;
                    shift_next     = '0;
                    frame_err_next = (cnt_reg != '0);
                end else if (sclk_rise) begin
                    if (cnt_reg == LAST_BIT) begin
                        word_done  = 1'b1;
                        cnt_next   = '0;
                        state_next = HOLD;
                    end else begin
                        shift_next = SHIFT_W'({shift_reg, sdata_sync});
                        cnt_next   = cnt_reg + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (word_done) begin
            if (!valid_reg || out_ready) begin
                instr_next = {shift_reg, sdata_sync};
                valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
    end

    assign out_instr = instr_reg;
    assign out_valid = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != IDLE);

endmodule
